// File: rtl/fsk_modulator.sv
// Continuous-phase FSK modulator: accumulates INC0/INC1 per sample for SPB samples per bit,
// with a ready/valid bit handshake that allows gapless back-to-back bits.
module fsk_modulator #(
  parameter int                  PHASE_W = 16,
  parameter int                  SPB     = 16,
  parameter logic [PHASE_W-1:0]  INC0    = 'h1000,
  parameter logic [PHASE_W-1:0]  INC1    = 'h2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [PHASE_W-1:0] phase_out,
  output logic               sq_out,
  output logic               active,
  output logic               bit_done
);

  localparam int CW = (SPB > 2) ? $clog2(SPB) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPB - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]         state;
  logic               cur_bit;
  logic [CW-1:0]      cnt;
  logic [PHASE_W-1:0] phase;
  logic               last;
  logic               accept;

  assign last      = (state == SEND) && (cnt == CNT_LAST);
  assign bit_ready = !rst && ((state == IDLE) || last);
  assign accept    = bit_valid && bit_ready;

  // Phase is never cleared outside reset, so it stays continuous across bits and idle gaps.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= '0;
      cur_bit <= 1'b0;
      cnt     <= '0;
    end else begin
      if (state == SEND)
        phase <= phase + (cur_bit ? INC1 : INC0);
      if (accept) begin
        state   <= SEND;
        cur_bit <= bit_in;
        cnt     <= '0;
      end else if (last) begin
        state <= IDLE;
        cnt   <= '0;
      end else if (state == SEND) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign phase_out = phase;
  assign sq_out    = phase[PHASE_W-1];
  assign active    = (state == SEND);
  assign bit_done  = last;

endmodule

// File: tb/tb_fsk_modulator.sv
// Directed bench for fsk_modulator with SPB=4, INC0=0x1000, INC1=0x2000.
module tb_fsk_modulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic [15:0] phase_out;
  logic        sq_out;
  logic        active;
  logic        bit_done;

  int nvec = 0;
  int nmis = 0;

  fsk_modulator #(.PHASE_W(16), .SPB(4), .INC0(16'h1000), .INC1(16'h2000)) dut (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .phase_out(phase_out), .sq_out(sq_out), .active(active), .bit_done(bit_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] seq01 [8] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000,
                             16'h6000, 16'h8000, 16'hA000, 16'hC000};

  initial begin
    // reset and idle hold
    tick(); tick();
    chk("rst_phase", 32'(phase_out), 32'h0);
    chk("rst_sq", 32'(sq_out), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    chk("rst_done", 32'(bit_done), 32'h0);
    chk("rst_ready", 32'(bit_ready), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_phase", 32'(phase_out), 32'h0);
      chk("idle_active", 32'(active), 32'h0);
      chk("idle_ready", 32'(bit_ready), 32'h1);
    end

    // single 1 bit
    bit_in = 1'b1; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    chk("b1_active", 32'(active), 32'h1);
    chk("b1_ready0", 32'(bit_ready), 32'h0);
    chk("b1_phase0", 32'(phase_out), 32'h0);
    for (int k = 1; k <= 4; k++) begin
      chk("b1_done", 32'(bit_done), 32'(k == 4));
      chk("b1_ready", 32'(bit_ready), 32'(k == 4));
      tick();
      chk("b1_phase", 32'(phase_out), 32'(16'h2000 * k));
    end
    chk("b1_idle", 32'(active), 32'h0);
    chk("b1_sq", 32'(sq_out), 32'h1);
    tick();
    chk("b1_hold", 32'(phase_out), 32'h8000);

    // continuity across the idle gap: a 0 bit starts from 0x8000
    bit_in = 1'b0; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    tick();
    chk("gap_phase", 32'(phase_out), 32'h9000);
    tick(); tick(); tick();
    chk("gap_end", 32'(phase_out), 32'hC000);
    chk("gap_idle", 32'(active), 32'h0);

    // back-to-back 0 then 1 from phase 0
    rst = 1'b1; tick(); rst = 1'b0;
    bit_in = 1'b0; bit_valid = 1'b1;
    tick();
    bit_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) bit_valid = 1'b0;
      #1;
      chk("b2b_ready", 32'(bit_ready), 32'(i % 4 == 3));
      chk("b2b_active", 32'(active), 32'h1);
      tick();
      chk("b2b_phase", 32'(phase_out), 32'(seq01[i]));
    end
    chk("b2b_idle", 32'(active), 32'h0);

    // two 1 bits wrap to zero
    rst = 1'b1; tick(); rst = 1'b0;
    bit_in = 1'b1; bit_valid = 1'b1;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) bit_valid = 1'b0;
      tick();
      if (i == 7) chk("wrap_sq7", 32'(sq_out), 32'h1);
    end
    chk("wrap_phase", 32'(phase_out), 32'h0);
    chk("wrap_sq8", 32'(sq_out), 32'h0);

    // reset mid-bit aborts without bit_done
    bit_in = 1'b1; bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    tick();
    chk("abort_pre", 32'(phase_out), 32'h2000);
    rst = 1'b1;
    #1;
    chk("abort_rdy_rst", 32'(bit_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("abort_phase", 32'(phase_out), 32'h0);
    chk("abort_active", 32'(active), 32'h0);
    chk("abort_ready", 32'(bit_ready), 32'h1);
    for (int i = 0; i < 4; i++) begin
      chk("abort_nodone", 32'(bit_done), 32'h0);
      tick();
      chk("abort_hold", 32'(phase_out), 32'h0);
    end

    // bit_in toggling mid-bit is ignored
    bit_in = 1'b0; bit_valid = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      bit_in = ~bit_in;
      tick();
      chk("tog_phase", 32'(phase_out), 32'(16'h1000 * i));
    end
    bit_valid = 1'b0;
    tick();
    chk("tog_end", 32'(phase_out), 32'h4000);
    chk("tog_idle", 32'(active), 32'h0);

    // reset wins over a simultaneous handshake
    rst = 1'b1; bit_in = 1'b1; bit_valid = 1'b1;
    tick();
    rst = 1'b0; bit_valid = 1'b0;
    tick();
    chk("rstpri_active", 32'(active), 32'h0);
    chk("rstpri_phase", 32'(phase_out), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule

// File: doc/fsk_modulator.md
FSK_MODULATOR -- requirements
Module: fsk_modulator

Interface
REQ-001 Parameter PHASE_W, default 16: phase accumulator width in bits.
REQ-002 Parameter SPB, default 16: clock cycles (samples) per bit, legal range 2..65535.
REQ-003 Parameter INC0, default 16'h1000: phase increment used while transmitting a 0 bit.
REQ-004 Parameter INC1, default 16'h2000: phase increment used while transmitting a 1 bit.
REQ-005 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port rst, input, 1: reset, synchronous and active-high.
REQ-007 Port bit_in, input, 1: serial data bit from the upstream serializer.
REQ-008 Port bit_valid, input, 1: bit_in holds a bit to be transmitted.
REQ-009 Port bit_ready, output, 1: the block accepts bit_in on this edge if bit_valid=1.
REQ-010 Port phase_out, output, PHASE_W: current accumulator phase.
REQ-011 Port sq_out, output, 1: square-wave FSK output, equal to phase_out[PHASE_W-1].
REQ-012 Port active, output, 1: high while a bit is being transmitted.
REQ-013 Port bit_done, output, 1: one-cycle pulse in the final sample cycle of each bit.

Function
REQ-014 The FSM SHALL have two states, IDLE and SEND.
REQ-015 A bit is accepted on a rising edge where bit_valid=1 and bit_ready=1; bit_in is latched into cur_bit and the sample counter is cleared.
REQ-016 bit_ready SHALL be 1 in IDLE, 1 in SEND when sample counter = SPB-1, 0 otherwise, and forced 0 while rst=1 (combinational).
REQ-017 IDLE -> SEND on acceptance; phase holds and active=0 while in IDLE.
REQ-018 In SEND, each edge SHALL add INC1 (cur_bit=1) or INC0 (cur_bit=0) to the phase and increment the sample counter.
REQ-019 Phase arithmetic SHALL be modulo 2^PHASE_W; overflow wraps silently, with no saturation and no flag.
REQ-020 Phase SHALL be continuous across bit boundaries and across IDLE gaps (CPFSK); it is never cleared except by reset.
REQ-021 In SEND at counter = SPB-1: bit_done=1; with bit_valid=1 the new bit is accepted, counter cleared, state stays SEND (no gap cycle); with bit_valid=0 -> IDLE.
REQ-022 Latency: the first increment for an accepted bit occurs on the edge after acceptance; each bit occupies exactly SPB accumulate edges.
REQ-023 bit_valid while bit_ready=0 SHALL be ignored; bit_in changes mid-bit have no effect on cur_bit.
REQ-024 active SHALL be registered: 1 exactly in SEND state.
REQ-025 Sample counter width SHALL be ceil(log2(SPB)), minimum 1 bit.

Reset
REQ-026 With rst=1 on an edge: state=IDLE, phase_out=0, sq_out=0, cur_bit=0, counter=0, active=0, bit_done=0.
REQ-027 rst asserted mid-bit SHALL abort the bit in flight with no further accumulation; the abandoned bit is not re-requested.
REQ-028 rst SHALL take priority over a simultaneous bit_valid handshake; no bit is accepted on a reset edge.

Verification (PHASE_W=16, SPB=4, INC0=16'h1000, INC1=16'h2000)
REQ-029 Reset, then release, bit_valid=0 -> phase_out=0, sq_out=0, active=0, bit_ready=1, held indefinitely.
REQ-030 Single bit 1 accepted -> phase_out 2000,4000,6000,8000 on the next 4 edges; bit_done high in the 4th cycle; then IDLE with phase holding 8000 and sq_out=1.
REQ-031 Back-to-back 0 then 1, bit_valid held -> phase 1000,2000,3000,4000,6000,8000,A000,C000; active continuously 1; bit_ready high only in cycles where counter=3.
REQ-032 Two consecutive 1 bits from phase 0 -> phase reaches 0000 on the 8th edge (wrap); sq_out falls at the 8th edge.
REQ-033 rst asserted on the 2nd sample of a 1 bit -> next edge gives phase_out=0, active=0, bit_ready=1; no bit_done pulse for the aborted bit.
REQ-034 bit_valid=1 with bit_in toggling during counter 0..2 -> no acceptance and no cur_bit change; the increment stays constant for the whole bit.
